// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame writer.
//   state_t  : writer control states
//   NUM_BITS : default sample / memory word width
//   FRAME_LEN: default samples per frame (equals FFT memory depth)
//   ADDR_W   : default memory address width, log2(FRAME_LEN)
//   sample_t : one ADC sample at the default width
package fft_pkg;

    localparam int NUM_BITS  = 10;
    localparam int FRAME_LEN = 2048;
    localparam int ADDR_W    = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    typedef logic [NUM_BITS-1:0] sample_t;

endpackage

// File: rtl/fft_decimator.sv
// Accumulate-and-shift decimation stage. Sums 2^DECIM_LOG2 accepted samples
// and, on the last sample of each group, presents sum >> DECIM_LOG2.
// The output is combinational on the last sample so that the caller's
// register stage gives a one-cycle write latency.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : synchronous clear of accumulator and group counter
//   in_valid   : sample strobe
//   in_data    : sample
//   out_valid  : group complete this cycle
//   out_data   : truncated group mean
module fft_decimator #(
    parameter int NUM_BITS   = 10,
    parameter int DECIM_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [NUM_BITS-1:0] in_data,
    output logic                out_valid,
    output logic [NUM_BITS-1:0] out_data
);

    localparam int ACC_W = NUM_BITS + DECIM_LOG2;

    logic [ACC_W-1:0]      acc;
    logic [DECIM_LOG2-1:0] cnt;
    logic [ACC_W-1:0]      sum;
    logic                  last;

    assign sum       = acc + ACC_W'(in_data);
    assign last      = &cnt;
    assign out_valid = in_valid && last;
    assign out_data  = sum[ACC_W-1:DECIM_LOG2];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_valid) begin
            // Group counter wraps naturally at 2^DECIM_LOG2.
            acc <= last ? '0 : sum;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fft_frame_writer.sv
// Writes FRAME_LEN consecutive ADC samples into the single-port FFT memory
// at addresses 0..FRAME_LEN-1, then hands the port to the FFT engine via
// frame_valid/frame_ack. Samples arriving while the FFT owns the memory are
// dropped and counted (saturating).
// Optional build macro FFT_FRAME_WRITER_DECIM_EN: each memory word becomes
// the truncated mean of 2^DECIM_LOG2 input samples.
//   clk, rst_n            : clock, synchronous active-low reset
//   enable                : capture enable
//   smp_valid, smp_data   : ADC sample strobe and value (no backpressure)
//   mem_we/addr/data      : FFT memory write port
//   mem_owner             : 1 = writer owns the port, 0 = FFT engine
//   frame_valid/frame_ack : frame handoff handshake
//   drop_cnt              : saturating dropped-sample count
module fft_frame_writer #(
    parameter int NUM_BITS   = fft_pkg::NUM_BITS,
    parameter int FRAME_LEN  = fft_pkg::FRAME_LEN,
    parameter int ADDR_W     = fft_pkg::ADDR_W,
`ifdef FFT_FRAME_WRITER_DECIM_EN
    parameter int DECIM_LOG2 = 2,
`endif
    parameter int DROP_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                smp_valid,
    input  logic [NUM_BITS-1:0] smp_data,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [NUM_BITS-1:0] mem_data,
    output logic                mem_owner,
    output logic                frame_valid,
    input  logic                frame_ack,
    output logic [DROP_W-1:0]   drop_cnt
);

    import fft_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    state_t              state_q, state_n;
    logic [ADDR_W-1:0]   ptr_q, ptr_n;
    logic                we_n, owner_n, fv_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [NUM_BITS-1:0] data_n;
    logic [DROP_W-1:0]   drop_n;

    // Word to be written this cycle (direct sample or decimated group).
    logic                wr_valid;
    logic [NUM_BITS-1:0] wr_data;

`ifdef FFT_FRAME_WRITER_DECIM_EN
    logic decim_clear;

    // Clear on every entry to FILL; depends only on registered state so it
    // never loops back through the decimator output.
    assign decim_clear = enable &&
                         ((state_q == IDLE) ||
                          (state_q == READY && frame_valid && frame_ack));

    fft_decimator #(
        .NUM_BITS   (NUM_BITS),
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_decim (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (decim_clear),
        .in_valid  (smp_valid && state_q == FILL),
        .in_data   (smp_data),
        .out_valid (wr_valid),
        .out_data  (wr_data)
    );
`else
    assign wr_valid = smp_valid;
    assign wr_data  = smp_data;
`endif

    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        we_n    = 1'b0;
        addr_n  = mem_addr;
        data_n  = mem_data;
        owner_n = mem_owner;
        fv_n    = frame_valid;
        drop_n  = drop_cnt;
        case (state_q)
            IDLE: begin
                owner_n = 1'b1;
                fv_n    = 1'b0;
                ptr_n   = '0;
                if (enable) state_n = FILL;
            end
            FILL: begin
                owner_n = 1'b1;
                fv_n    = 1'b0;
                if (wr_valid) begin
                    we_n   = 1'b1;
                    addr_n = ptr_q;
                    data_n = wr_data;
                    ptr_n  = ptr_q + 1'b1;
                    // Entering READY while the last pulse is on the port means
                    // frame_valid/mem_owner flip one cycle after it.
                    if (ptr_q == LAST_ADDR) begin
                        state_n = READY;
                        ptr_n   = '0;
                    end
                end
                // Abort discards the partial frame; a write issued this cycle
                // still goes out.
                if (!enable) begin
                    state_n = IDLE;
                    ptr_n   = '0;
                end
            end
            READY: begin
                owner_n = 1'b0;
                fv_n    = 1'b1;
                if (smp_valid && drop_cnt != '1) drop_n = drop_cnt + 1'b1;
                // Ack only counts once frame_valid is actually visible.
                if (frame_valid && frame_ack) begin
                    fv_n    = 1'b0;
                    owner_n = 1'b1;
                    ptr_n   = '0;
                    state_n = enable ? FILL : IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                ptr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_owner   <= 1'b1;
            frame_valid <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state_q     <= state_n;
            ptr_q       <= ptr_n;
            mem_we      <= we_n;
            mem_addr    <= addr_n;
            mem_data    <= data_n;
            mem_owner   <= owner_n;
            frame_valid <= fv_n;
            drop_cnt    <= drop_n;
        end
    end

endmodule

// File: tb/tb_fft_frame_writer.sv
// Directed bench for fft_frame_writer with a 16-entry frame.
module tb_fft_frame_writer;

    localparam int NB = 10;
    localparam int FL = 16;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          smp_valid = 1'b0;
    logic [NB-1:0] smp_data = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [NB-1:0] mem_data;
    logic          mem_owner;
    logic          frame_valid;
    logic          frame_ack = 1'b0;
    logic [DW-1:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fft_frame_writer #(
        .NUM_BITS  (NB),
        .FRAME_LEN (FL),
        .ADDR_W    (AW),
        .DROP_W    (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .smp_valid   (smp_valid),
        .smp_data    (smp_data),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_owner   (mem_owner),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .drop_cnt    (drop_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " we"},    int'(mem_we), 0);
        chk({tag, " addr"},  int'(mem_addr), 0);
        chk({tag, " data"},  int'(mem_data), 0);
        chk({tag, " owner"}, int'(mem_owner), 1);
        chk({tag, " fv"},    int'(frame_valid), 0);
        chk({tag, " drop"},  int'(drop_cnt), 0);
    endtask

    // One sample, one idle cycle; the write must show up one cycle later.
    task automatic put(input int d, input int exp_addr, input string tag);
        smp_valid = 1'b1;
        smp_data  = NB'(d);
        tick();
        smp_valid = 1'b0;
        chk({tag, " we"},   int'(mem_we), 1);
        chk({tag, " addr"}, int'(mem_addr), exp_addr);
        chk({tag, " data"}, int'(mem_data), d);
        tick();
        chk({tag, " we pulse"},  int'(mem_we), 0);
        chk({tag, " addr hold"}, int'(mem_addr), exp_addr);
    endtask

    // Sample accepted with no write expected (dropped / ignored).
    task automatic put_nowr(input int d, input string tag);
        smp_valid = 1'b1;
        smp_data  = NB'(d);
        tick();
        smp_valid = 1'b0;
        chk({tag, " no we"}, int'(mem_we), 0);
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

`ifndef FFT_FRAME_WRITER_DECIM_EN
        // Full frame, samples 0..15, one every 3 cycles.
        enable = 1'b1;
        tick();
        for (int i = 0; i < FL; i++) begin
            smp_valid = 1'b1;
            smp_data  = NB'(i);
            tick();
            smp_valid = 1'b0;
            chk("fill we", int'(mem_we), 1);
            chk("fill addr", int'(mem_addr), i);
            chk("fill data", int'(mem_data), i);
            chk("fill fv during pulse", int'(frame_valid), 0);
            chk("fill owner during pulse", int'(mem_owner), 1);
            tick();
            chk("fill we pulse", int'(mem_we), 0);
            chk("fill fv after", int'(frame_valid), (i == FL-1) ? 1 : 0);
            chk("fill owner after", int'(mem_owner), (i == FL-1) ? 0 : 1);
            tick();
        end

        // Drops while READY.
        for (int i = 0; i < 5; i++) put_nowr(i + 100, "drop");
        chk("drop cnt", int'(drop_cnt), 5);
        chk("drop fv held", int'(frame_valid), 1);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ack fv", int'(frame_valid), 0);
        chk("ack owner", int'(mem_owner), 1);
        put(10'h3FF, 0, "post-ack");

        // Abort after 7 writes in this frame.
        for (int i = 1; i < 7; i++) put(i + 32, i, "pre-abort");
        enable = 1'b0;
        tick();
        tick();
        chk("abort fv", int'(frame_valid), 0);
        chk("abort owner", int'(mem_owner), 1);
        put_nowr(10'h111, "idle ignore");
        chk("idle drop unchanged", int'(drop_cnt), 5);
        enable = 1'b1;
        tick();
        put(10'h155, 0, "re-enable");

        // Complete frame then ack with a simultaneous sample.
        for (int i = 1; i < FL; i++) put(i + 64, i, "fill2");
        chk("fill2 fv", int'(frame_valid), 1);
        smp_valid = 1'b1;
        smp_data  = NB'(10'h0AB);
        frame_ack = 1'b1;
        tick();
        smp_valid = 1'b0;
        frame_ack = 1'b0;
        chk("simul drop", int'(drop_cnt), 6);
        chk("simul fv", int'(frame_valid), 0);
        chk("simul no we", int'(mem_we), 0);
        put(10'h2AA, 0, "post-simul");

        // Reset mid-frame with ptr at 9.
        for (int i = 1; i < 9; i++) put(i + 200, i, "pre-reset");
        rst_n = 1'b0;
        tick();
        chk_reset_vals("mid reset");
        rst_n = 1'b1;
        tick();
        put(7, 0, "post-reset");
`else
        // Decimation by 4: 4,5,6,8 -> 23>>2 = 5.
        enable = 1'b1;
        tick();
        put_nowr(4, "decim s0");
        put_nowr(5, "decim s1");
        put_nowr(6, "decim s2");
        put(8, 0, "decim grp0");
        // 15 more groups of constant k+1 complete the frame.
        for (int g = 1; g < FL; g++) begin
            for (int s = 0; s < 3; s++) put_nowr(g + 1, "decim in");
            put(g + 1, g, "decim grp");
        end
        chk("decim fv", int'(frame_valid), 1);
        chk("decim owner", int'(mem_owner), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
